wide_add_seq: RTL
=================

Name: wide_add_seq

Overview:
Multi-cycle sequencer that performs NBYTES-wide add/subtract using a single 8-bit ripple-carry adder slice, one byte per cycle, LSB first. It holds the carry between bytes in a register and collects sum bytes into a result register. It sits between a valid/ready producer and a valid/ready consumer. It gives wide arithmetic at 8-bit adder area cost.

Parameters:
NBYTES, 4, operand width in bytes; legal range 2..16; operand width W = 8*NBYTES.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operand request valid
in_ready  out  1  block can accept request
in_a  in  W  operand A
in_b  in  W  operand B
in_sub  in  1  0 = A+B, 1 = A-B (two's complement)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_sum  out  W  result
out_cout  out  1  final carry out; for subtract, 1 = no borrow
out_ovf  out  1  signed overflow
out_zero  out  1  out_sum == 0
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n. While rst_n=0 at a rising edge: state=IDLE, byte index=0, carry reg=0, all result registers=0, out_valid=0. in_ready is combinational and reads 0 while rst_n=0.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_a, in_b and in_sub, clear the byte index, then go to RUN.
  - RUN: each cycle processes byte k (k = 0..NBYTES-1).
    - Adder inputs: a = A[8k+7:8k]; b = in_sub ? ~B[8k+7:8k] : B[8k+7:8k]; cin = (k==0) ? in_sub : carry_reg.
    - At the edge: write sum byte k, set carry_reg = adder cout, k <= k+1.
    - After byte NBYTES-1: go to DONE, set out_valid=1, out_cout = last cout.
    - out_ovf = (A_msb == b_eff_msb) && (sum_msb != A_msb).
    - out_zero comes from the full result.
  - DONE: out_valid=1. All out_* registers stay stable until out_valid&out_ready.
    - On that handshake, go to IDLE, unless a new request is accepted in the same cycle.
- in_ready = IDLE || (DONE && out_ready). A request accepted in DONE goes straight to RUN, and out_valid drops at the next edge.
- Latency: for a request accepted at edge E, out_valid rises at edge E+NBYTES. Back-to-back throughput is one result per NBYTES+1 cycles.
- Data path rules:
  - Operands are captured at acceptance. Input changes after acceptance are ignored.
  - out_sum is registered. Bytes not yet written hold the previous result until overwritten; consumers sample only while out_valid=1.
  - Byte index width is $clog2(NBYTES). The index never wraps past NBYTES-1; the RUN exit is decoded on k==NBYTES-1.
- Reset mid-operation: an in-flight RUN or DONE is aborted with no out_valid. The first cycle after reset release is IDLE with in_ready=1.
- in_valid in RUN is ignored, since in_ready=0. out_ready outside DONE has no effect.

Decomposition:
- Shared package wide_add_pkg:
  - state enum {IDLE, RUN, DONE}
  - constants BYTE_W=8, NBYTES_MAX=16
- The one natural sub-module is the existing rca_8bit, instantiated once as the byte slice. All control and registers stay in wide_add_seq.

Test Plan:
- Byte-boundary carry. With NBYTES=4, add 0x000000FF + 0x00000001. Required: out_sum=0x00000100, cout=0, ovf=0, zero=0, out_valid exactly 4 edges after acceptance.
- Full ripple. Add 0xFFFFFFFF + 0x00000001. Required: out_sum=0x00000000, cout=1, zero=1, ovf=0.
- Signed overflow.
  - Add 0x7FFFFFFF + 0x00000001. Required: out_sum=0x80000000, ovf=1, cout=0.
  - Subtract 0x80000000 - 0x00000001. Required: out_sum=0x7FFFFFFF, ovf=1.
- Subtract.
  - 0x00000005 - 0x00000007. Required: out_sum=0xFFFFFFFE, cout=0, ovf=0.
  - 0x00000007 - 0x00000005. Required: out_sum=0x00000002, cout=1.
- Backpressure. Hold out_ready=0 for 3 cycles in DONE. Required: outputs stable and in_ready=0. Then raise out_ready with in_valid=1 and new operands in the same cycle. Required: new request accepted in that cycle, out_valid low next cycle, second result after 4 more edges.
- Mid-operation reset. Assert rst_n=0 for one edge while k=2. Required: out_valid=0, busy=0, out_sum=0. Next, 0x12345678 + 0x11111111 completes correctly as 0x23456789.

Source files
------------

// File: rtl/wide_add_pkg.sv
// rtl/wide_add_pkg.sv - shared state type and widths for the byte-serial wide adder
package wide_add_pkg;

   localparam int BYTE_W     = 8;
   localparam int NBYTES_MAX = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : wide_add_pkg

// File: rtl/rca_8bit.sv
// rtl/rca_8bit.sv - 8-bit ripple-carry adder slice
module rca_8bit
   import wide_add_pkg::*;
(
   input  logic [BYTE_W-1:0] a_i,
   input  logic [BYTE_W-1:0] b_i,
   input  logic              cin_i,
   output logic [BYTE_W-1:0] sum_o,
   output logic              cout_o
);

   logic [BYTE_W:0] c;

   always_comb begin
      c     = '0;
      sum_o = '0;
      c[0]  = cin_i;
      for (int i = 0; i < BYTE_W; i++) begin
         sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
         c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
      end
      cout_o = c[BYTE_W];
   end

endmodule : rca_8bit

// File: rtl/wide_add_seq.sv
// rtl/wide_add_seq.sv - NBYTES-wide add/subtract sequenced one byte per cycle, LSB first,
// through a single 8-bit slice with valid/ready on both sides.
module wide_add_seq
   import wide_add_pkg::*;
#(
   parameter int NBYTES = 4
)
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [BYTE_W*NBYTES-1:0] in_a,
   input  logic [BYTE_W*NBYTES-1:0] in_b,
   input  logic                     in_sub,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [BYTE_W*NBYTES-1:0] out_sum,
   output logic                     out_cout,
   output logic                     out_ovf,
   output logic                     out_zero,
   output logic                     busy
);

   localparam int W  = BYTE_W * NBYTES;
   localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

   state_t        state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic          carry_q, carry_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic          sub_q, sub_d;
   logic [W-1:0]  sum_q, sum_d;
   logic          cout_q, cout_d;
   logic          ovf_q, ovf_d;
   logic          zero_q, zero_d;

   logic              accept;
   logic              last_byte;
   logic [BYTE_W-1:0] byte_a;
   logic [BYTE_W-1:0] byte_b;
   logic [BYTE_W-1:0] byte_b_eff;
   logic              slice_cin;
   logic [BYTE_W-1:0] slice_sum;
   logic              slice_cout;

   assign accept    = in_valid & in_ready;
   assign last_byte = (k_q == K_LAST);

   // Operand byte select; subtract feeds ~B with the LSB carry-in forced to 1.
   always_comb begin
      byte_a = '0;
      byte_b = '0;
      for (int i = 0; i < NBYTES; i++) begin
         if (k_q == KW'(i)) begin
            byte_a = a_q[BYTE_W*i +: BYTE_W];
            byte_b = b_q[BYTE_W*i +: BYTE_W];
         end
      end
      byte_b_eff = sub_q ? ~byte_b : byte_b;
      slice_cin  = (k_q == '0) ? sub_q : carry_q;
   end

   rca_8bit u_slice (
      .a_i    (byte_a),
      .b_i    (byte_b_eff),
      .cin_i  (slice_cin),
      .sum_o  (slice_sum),
      .cout_o (slice_cout)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sub_q   <= sub_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = RUN;
         RUN:     if (last_byte) state_d = DONE;
         DONE: begin
            if (accept)         state_d = RUN;
            else if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      k_d     = k_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sub_d   = sub_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               a_d   = in_a;
               b_d   = in_b;
               sub_d = in_sub;
               k_d   = '0;
            end
         end
         RUN: begin
            for (int i = 0; i < NBYTES; i++) begin
               if (k_q == KW'(i)) sum_d[BYTE_W*i +: BYTE_W] = slice_sum;
            end
            carry_d = slice_cout;
            // Index holds at the last byte rather than wrapping; acceptance clears it.
            if (last_byte) begin
               cout_d = slice_cout;
               ovf_d  = (a_q[W-1] == byte_b_eff[BYTE_W-1]) &&
                        (slice_sum[BYTE_W-1] != a_q[W-1]);
               zero_d = (sum_d == '0);
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      in_ready  = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
      out_valid = (state_q == DONE);
      busy      = (state_q != IDLE);
   end

   assign out_sum  = sum_q;
   assign out_cout = cout_q;
   assign out_ovf  = ovf_q;
   assign out_zero = zero_q;

endmodule : wide_add_seq
